// File: rtl/updown_count_arbiter.sv
// updown_count_arbiter
// Round-robin arbiter in front of a shared WIDTH-bit up/down counter.
// One requester at a time is granted a counting run of its requested
// direction and step count; the counter moves one step per clock and the
// winner receives a one-cycle done pulse when the run completes.
// All outputs are registered so they change only on the clock edge.
module updown_count_arbiter #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req,
    input  logic [1:0]        req_dir,
    input  logic [STEP_W-1:0] req_steps0,
    input  logic [STEP_W-1:0] req_steps1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic              busy,
    output logic [WIDTH-1:0]  count,
    output logic              wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;       // index of granted requester
    logic                dir_q, dir_d;           // latched direction, 1 = up
    logic [STEP_W-1:0]   remaining_q, remaining_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic                last_q, last_d;         // last-served requester
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          done_q, done_d;
    logic                busy_q, busy_d;
    logic                wrap_q, wrap_d;

    logic                winner;
    logic                win_dir;
    logic [STEP_W-1:0]   win_steps;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Arbitration: on a tie the requester that was not served last wins.
    always_comb begin
        winner = 1'b0;
        if (req == 2'b11) begin
            winner = ~last_q;
        end else begin
            winner = req[1];
        end
        win_dir   = req_dir[winner];
        win_steps = winner ? req_steps1 : req_steps0;
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        dir_d       = dir_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        last_d      = last_q;
        wrap_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    owner_d     = winner;
                    dir_d       = win_dir;
                    remaining_d = win_steps;
                    state_d     = (win_steps != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (dir_q) begin
                    count_d = count_q + WIDTH'(1);
                    wrap_d  = (count_q == '1);
                end else begin
                    count_d = count_q - WIDTH'(1);
                    wrap_d  = (count_q == '0);
                end
                remaining_d = remaining_q - STEP_W'(1);
                if (remaining_q == STEP_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                last_d  = owner_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the upcoming state so they register
        // in step with it.
        gnt_d  = (state_d == ST_RUN)  ? onehot(owner_d) : 2'b00;
        done_d = (state_d == ST_DONE) ? onehot(owner_d) : 2'b00;
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            dir_q       <= 1'b0;
            remaining_q <= '0;
            count_q     <= '0;
            last_q      <= 1'b1;
            gnt_q       <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            dir_q       <= dir_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            last_q      <= last_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            wrap_q      <= wrap_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign count = count_q;
    assign wrap  = wrap_q;

    // Structural invariants of the grant/done outputs.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(gnt_q));
    a_done_excl : assert property (@(posedge clk) disable iff (!rst_n)
        (gnt_q & done_q) == 2'b00);

endmodule
